// File: rtl/hilo_unit_pkg.sv
// Shared op encodings, FSM state type and default latencies for the HI/LO unit.
package hilo_unit_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int DEF_DIV_LATENCY = 8;
    localparam int DEF_MUL_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

endpackage

// File: rtl/hilo_unit_if.sv
// Issue, divider and HI/LO result signals of the HI/LO unit.
// slave = the unit itself; master = pipeline plus external divider.
interface hilo_unit_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  op_valid, op, rs_val, rt_val, quotient, remainder,
        output div_a, div_b, busy, hi, lo
    );

    modport master (
        output op_valid, op, rs_val, rt_val, quotient, remainder,
        input  div_a, div_b, busy, hi, lo
    );
endinterface

// File: rtl/hilo_unit_sign_fix.sv
// Conditional 32-bit two's-complement negate; purely combinational.
// Used both to strip signs before the divider and to restore them after.
module hilo_sign_fix (
    input  logic [31:0] val,
    input  logic        neg,
    output logic [31:0] res
);
    assign res = neg ? (~val + 32'd1) : val;
endmodule

// File: rtl/hilo_unit.sv
// Multi-cycle HI/LO unit: MULT/MULTU/DIV/DIVU commit LATENCY edges after issue, MTHI/MTLO same edge.
// busy stalls upstream while in flight; any op_valid seen while busy is dropped.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DIV_LATENCY = DEF_DIV_LATENCY,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  bus
);

    state_t      state;
    logic [15:0] cnt;
    logic [31:0] a_q, b_q;
    logic        sign_a, sign_b;
    logic        busy_q;
    logic [31:0] hi_q, lo_q, div_a_q, div_b_q;

    logic        op_signed, in_sign_a, in_sign_b;
    logic [31:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [63:0] product;

    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign in_sign_a = bus.rs_val[31] & op_signed;
    assign in_sign_b = bus.rt_val[31] & op_signed;

    hilo_sign_fix u_abs_a (.val(bus.rs_val),    .neg(in_sign_a),       .res(abs_a));
    hilo_sign_fix u_abs_b (.val(bus.rt_val),    .neg(in_sign_b),       .res(abs_b));
    hilo_sign_fix u_quo   (.val(bus.quotient),  .neg(sign_a ^ sign_b), .res(quo_fix));
    hilo_sign_fix u_rem   (.val(bus.remainder), .neg(sign_a),          .res(rem_fix));

    // Sign-extending to 64 bits lets one unsigned multiply serve both MULT and MULTU.
    assign product = {{32{sign_a}}, a_q} * {{32{sign_b}}, b_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                a_q    <= bus.rs_val;
                                b_q    <= bus.rt_val;
                                sign_a <= in_sign_a;
                                sign_b <= in_sign_b;
                                busy_q <= 1'b1;
                                if (bus.op == OP_MULT || bus.op == OP_MULTU) begin
                                    state <= MUL;
                                    cnt   <= 16'(MUL_LATENCY - 1);
                                end else begin
                                    state   <= DIV;
                                    cnt     <= 16'(DIV_LATENCY - 1);
                                    div_a_q <= abs_a;
                                    div_b_q <= abs_b;
                                end
                            end
                            OP_MTHI: hi_q <= bus.rs_val;
                            OP_MTLO: lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (cnt == 16'd0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (state == MUL) begin
                            hi_q <= product[63:32];
                            lo_q <= product[31:0];
                        end else if (b_q != 32'd0) begin
                            // Divide by zero leaves HI/LO untouched.
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.div_a = div_a_q;
    assign bus.div_b = div_b_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed-vector bench for hilo_unit with a behavioural unsigned divider on div_a/div_b.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hilo_unit_if bus ();

    hilo_unit #(.DIV_LATENCY(8), .MUL_LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.quotient  = (bus.div_b == 32'd0) ? 32'hFFFF_FFFF : bus.div_a / bus.div_b;
    assign bus.remainder = (bus.div_b == 32'd0) ? bus.div_a     : bus.div_a % bus.div_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op for one edge; returns 1 time unit after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.op       = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
    endtask

    // Counts busy cycles until busy drops, bounded at 20.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.op = OP_NONE;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.div_a, bus.div_b} !== 129'd0) begin
            errors++;
            $display("FAIL reset_state hi=%h lo=%h busy=%b div_a=%h div_b=%h expected all zero",
                     bus.hi, bus.lo, bus.busy, bus.div_a, bus.div_b);
        end
    endtask

    task automatic test_divu;
        int n;
        issue(OP_DIVU, 32'd100, 32'd7);
        checks++;
        if (bus.div_a !== 32'd100 || bus.div_b !== 32'd7) begin
            errors++;
            $display("FAIL divu_operands div_a=%h div_b=%h expected 64/7", bus.div_a, bus.div_b);
        end
        wait_idle(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL divu_busy_cycles got %0d expected 8", n);
        end
        checks++;
        if (bus.lo !== 32'h0000_000E || bus.hi !== 32'h0000_0002) begin
            errors++;
            $display("FAIL divu_result hi=%h lo=%h expected hi=2 lo=e", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_signed;
        int n;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (bus.div_a !== 32'd7 || bus.div_b !== 32'd2) begin
            errors++;
            $display("FAIL div_abs_operands div_a=%h div_b=%h expected 7/2", bus.div_a, bus.div_b);
        end
        wait_idle(n);
        checks++;
        if (n != 8 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg n=%0d hi=%h lo=%h expected n=8 hi=ffffffff lo=fffffffd", n, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_overflow;
        int n;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0000_0000) begin
            errors++;
            $display("FAIL div_overflow hi=%h lo=%h expected hi=0 lo=80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_zero;
        int n;
        issue(OP_MTHI, 32'h11, 32'd0);
        checks++;
        if (bus.hi !== 32'h11 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi hi=%h busy=%b expected hi=11 busy=0", bus.hi, bus.busy);
        end
        issue(OP_MTLO, 32'h22, 32'd0);
        checks++;
        if (bus.lo !== 32'h22 || bus.hi !== 32'h11 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo hi=%h lo=%h busy=%b expected hi=11 lo=22 busy=0", bus.hi, bus.lo, bus.busy);
        end
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_idle(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL divzero_busy_cycles got %0d expected 8", n);
        end
        checks++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            errors++;
            $display("FAIL divzero_unchanged hi=%h lo=%h expected hi=11 lo=22", bus.hi, bus.lo);
        end
    endtask

    task automatic test_mul;
        int n;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        checks++;
        if (n != 4 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult n=%0d hi=%h lo=%h expected n=4 hi=ffffffff lo=fffffffe", n, bus.hi, bus.lo);
        end
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        issue(OP_MTLO, 32'h55, 32'd0);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFE || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mtlo_while_busy lo=%h busy=%b expected lo=fffffffe busy=1", bus.lo, bus.busy);
        end
        wait_idle(n);
        checks++;
        if (n != 3 || bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu n=%0d hi=%h lo=%h expected n=3 hi=1 lo=fffffffe", n, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid;
        logic moved;
        issue(OP_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.div_a, bus.div_b} !== 129'd0) begin
            errors++;
            $display("FAIL reset_mid hi=%h lo=%h busy=%b div_a=%h div_b=%h expected all zero",
                     bus.hi, bus.lo, bus.busy, bus.div_a, bus.div_b);
        end
        moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) moved = 1'b1;
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_commit hi=%h lo=%h busy=%b expected zeros held", bus.hi, bus.lo, bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_divu();
        test_div_signed();
        test_div_overflow();
        test_div_zero();
        test_mul();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
